// File: rtl/vga_text_scan.sv
// vga_text_scan: 80x30 text-mode scanner for 640x480@60 on a single pixel clock.
// Stage 0 owns the h/v/frame counters and drives the memory read address.
// Stage 1 picks the character byte and drives the font ROM address.
// Stage 2 picks the glyph bit. The output register then forms colour, syncs and blank.
// Each stage carries its own copy of sync/blank, so they stay aligned with the pixel.
module vga_text_scan #(
  parameter logic [11:0] FG_COLOR = 12'hFFF,
  parameter logic [11:0] BG_COLOR = 12'h000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [12:0] raddr,
  input  logic [31:0] dataout,
  output logic [11:0] font_addr,
  input  logic [7:0]  font_row,
  input  logic        cursor_en,
  input  logic [4:0]  cursor_row,
  input  logic [6:0]  cursor_col,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_blank_n
);

  logic [9:0]  h;
  logic [9:0]  v;
  logic [5:0]  frame_cnt;
  logic        h_end;
  logic        v_end;

  logic [12:0] cell_row;
  logic [12:0] cell_col;
  logic        hs0, vs0, vis0, cur0;

  logic [1:0]  s1_sel;
  logic [3:0]  s1_grow;
  logic [2:0]  s1_px;
  logic        s1_cur, s1_hs, s1_vs, s1_vis;
  logic [7:0]  char_code;

  logic [2:0]  s2_px;
  logic        s2_cur, s2_hs, s2_vs, s2_vis;
  logic        pix_bit;

  assign h_end = (h == 10'd799);
  assign v_end = (v == 10'd524);

  // Stage 0: pixel, line and frame counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h         <= '0;
      v         <= '0;
      frame_cnt <= '0;
    end else begin
      h <= h_end ? 10'd0 : h + 10'd1;
      if (h_end) begin
        v <= v_end ? 10'd0 : v + 10'd1;
        if (v_end) frame_cnt <= frame_cnt + 6'd1;
      end
    end
  end

  // Stage 0: cell address and per-pixel flags. Rows past 29 are not clamped.
  // The multiply by 80 is written as two shifts.
  always_comb begin
    cell_row = {7'd0, v[9:4]};
    cell_col = {6'd0, h[9:3]};
    raddr    = (cell_row << 6) + (cell_row << 4) + cell_col;
    hs0      = !((h >= 10'd656) && (h <= 10'd751));
    vs0      = !((v >= 10'd490) && (v <= 10'd491));
    vis0     = (h < 10'd640) && (v < 10'd480);
    cur0     = cursor_en && (v[9:4] == {1'b0, cursor_row}) && (h[9:3] == cursor_col)
               && (v[3:0] >= 4'd14) && !frame_cnt[5];
  end

  // Stage 1 register: the read word returns during this stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_sel  <= '0;
      s1_grow <= '0;
      s1_px   <= '0;
      s1_cur  <= 1'b0;
      s1_hs   <= 1'b1;
      s1_vs   <= 1'b1;
      s1_vis  <= 1'b0;
    end else begin
      s1_sel  <= raddr[1:0];
      s1_grow <= v[3:0];
      s1_px   <= h[2:0];
      s1_cur  <= cur0;
      s1_hs   <= hs0;
      s1_vs   <= vs0;
      s1_vis  <= vis0;
    end
  end

  // Stage 1: pick the cell's byte from the word (little-endian) and address the font.
  always_comb begin
    char_code = dataout[7:0];
    case (s1_sel)
      2'd0: char_code = dataout[7:0];
      2'd1: char_code = dataout[15:8];
      2'd2: char_code = dataout[23:16];
      2'd3: char_code = dataout[31:24];
      default: char_code = dataout[7:0];
    endcase
    font_addr = {char_code, s1_grow};
  end

  // Stage 2 register: the font row returns during this stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_px  <= '0;
      s2_cur <= 1'b0;
      s2_hs  <= 1'b1;
      s2_vs  <= 1'b1;
      s2_vis <= 1'b0;
    end else begin
      s2_px  <= s1_px;
      s2_cur <= s1_cur;
      s2_hs  <= s1_hs;
      s2_vs  <= s1_vs;
      s2_vis <= s1_vis;
    end
  end

  // Stage 2: bit 7 of the glyph row is the leftmost pixel; the cursor inverts it.
  assign pix_bit = font_row[3'd7 - s2_px] ^ s2_cur;

  // Output register: colour, syncs and blank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {vga_r, vga_g, vga_b} <= 12'h000;
      vga_hs                <= 1'b1;
      vga_vs                <= 1'b1;
      vga_blank_n           <= 1'b0;
    end else begin
      {vga_r, vga_g, vga_b} <= s2_vis ? (pix_bit ? FG_COLOR : BG_COLOR) : 12'h000;
      vga_hs                <= s2_hs;
      vga_vs                <= s2_vs;
      vga_blank_n           <= s2_vis;
    end
  end

endmodule
